// File: rtl/winocnn_pkg.sv
// Shared constants and types for the Winograd result path: tile geometry,
// default data widths, bank states and the per-group tag.
package winocnn_pkg;

    localparam int TILE_N = 6;
    localparam int RES_W  = 12;
    localparam int ACC_W  = 16;
    localparam int MAX_ID = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_state_e;

    typedef struct packed {
        logic [7:0] od;
        logic [8:0] x;
        logic [8:0] y;
        logic       size_type;
    } tile_tag_t;

    // Last row/col index written for a tile of the given size type.
    function automatic logic [2:0] last_idx(input logic size_type);
        return size_type ? 3'd3 : 3'(TILE_N - 1);
    endfunction

endpackage

// File: rtl/wino_result_collector_if.sv
// PE result port and output-memory write port of the result collector.
interface wino_pe_result_if #(parameter int RES_W = winocnn_pkg::RES_W);
    import winocnn_pkg::*;

    logic signed [RES_W-1:0] result_tile_i [TILE_N][TILE_N];
    logic                    result_valid_i;
    logic [7:0]              result_od_i;
    logic [8:0]              result_x_i;
    logic [8:0]              result_y_i;
    logic                    size_type_i;
    logic [4:0]              id_count_i;
    logic                    ready_o;

    modport master (
        output result_tile_i, result_valid_i, result_od_i, result_x_i, result_y_i,
               size_type_i, id_count_i,
        input  ready_o
    );
    modport slave (
        input  result_tile_i, result_valid_i, result_od_i, result_x_i, result_y_i,
               size_type_i, id_count_i,
        output ready_o
    );
endinterface

interface wino_mem_wr_if #(parameter int ACC_W = winocnn_pkg::ACC_W);
    logic                    mem_wr_en_o;
    logic                    mem_wr_ready_i;
    logic [7:0]              mem_wr_od_o;
    logic [8:0]              mem_wr_x_o;
    logic [8:0]              mem_wr_y_o;
    logic signed [ACC_W-1:0] mem_wr_data_o;
    logic                    group_done_o;

    modport master (
        output mem_wr_en_o, mem_wr_od_o, mem_wr_x_o, mem_wr_y_o, mem_wr_data_o, group_done_o,
        input  mem_wr_ready_i
    );
    modport slave (
        input  mem_wr_en_o, mem_wr_od_o, mem_wr_x_o, mem_wr_y_o, mem_wr_data_o, group_done_o,
        output mem_wr_ready_i
    );
endinterface

// File: rtl/wino_acc_bank.sv
// One TILE_N x TILE_N accumulation bank: load (clear+add) or saturating add of a
// whole result tile, plus an element read mux for the drain side.
module wino_acc_bank #(
    parameter int RES_W = winocnn_pkg::RES_W,
    parameter int ACC_W = winocnn_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    load,
    input  logic                    add,
    input  logic signed [RES_W-1:0] tile_in [winocnn_pkg::TILE_N][winocnn_pkg::TILE_N],
    input  logic [2:0]              rd_row,
    input  logic [2:0]              rd_col,
    output logic signed [ACC_W-1:0] rd_data
);
    import winocnn_pkg::*;

    localparam logic signed [ACC_W:0] SAT_MAX = $signed({2'b00, {(ACC_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] SAT_MIN = $signed({2'b11, {(ACC_W-1){1'b0}}});

    logic signed [ACC_W-1:0] acc [TILE_N][TILE_N];

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [RES_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W-RES_W+1){b[RES_W-1]}}, b});
        if (s > SAT_MAX)      sat_add = SAT_MAX[ACC_W-1:0];
        else if (s < SAT_MIN) sat_add = SAT_MIN[ACC_W-1:0];
        else                  sat_add = s[ACC_W-1:0];
    endfunction

    // NOTE: the array has no reset; a bank is always loaded before it is read.
    always_ff @(posedge clk) begin
        if (load || add) begin
            for (int r = 0; r < TILE_N; r++) begin
                for (int c = 0; c < TILE_N; c++) begin
                    acc[r][c] <= sat_add(load ? '0 : acc[r][c], tile_in[r][c]);
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_row < 3'(TILE_N) && rd_col < 3'(TILE_N)) rd_data = acc[rd_row][rd_col];
    end

endmodule

// File: rtl/wino_result_collector.sv
// Accumulates PE result tiles over the ID dimension into two ping-pong banks and
// drains each finished bank to output memory one element per handshake.
module wino_result_collector #(
    parameter int RES_W = winocnn_pkg::RES_W,
    parameter int ACC_W = winocnn_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    wino_pe_result_if.slave   res,
    wino_mem_wr_if.master     mem,
    output logic              overflow_o,
    output logic              mismatch_o
);
    import winocnn_pkg::*;

    localparam logic [0:0] D_IDLE  = 1'b0;
    localparam logic [0:0] D_WRITE = 1'b1;

    bank_state_e             bank_state [2];
    tile_tag_t               bank_tag   [2];
    logic                    acc_ptr, drn_ptr;
    logic [4:0]              tile_cnt, id_target;
    logic [0:0]              d_state;
    logic [2:0]              row, col;
    logic signed [ACC_W-1:0] rd_data [2];

    logic       accept, first_tile, tile_done, tag_diff, wr_hs, last_elem, row_end;
    logic [4:0] id_eff, cnt_next, tgt_next;
    tile_tag_t  in_tag, drn_tag;

    assign res.ready_o = (bank_state[acc_ptr] == EMPTY) || (bank_state[acc_ptr] == ACCUM);

    always_comb begin
        in_tag     = '{od: res.result_od_i, x: res.result_x_i, y: res.result_y_i,
                       size_type: res.size_type_i};
        accept     = res.result_valid_i && res.ready_o;
        first_tile = bank_state[acc_ptr] == EMPTY;
        id_eff     = (res.id_count_i == 5'd0) ? 5'd1 : res.id_count_i;
        tgt_next   = first_tile ? id_eff : id_target;
        cnt_next   = first_tile ? 5'd1 : tile_cnt + 5'd1;
        tile_done  = cnt_next >= tgt_next;
        tag_diff   = (in_tag.od != bank_tag[acc_ptr].od) || (in_tag.x != bank_tag[acc_ptr].x)
                  || (in_tag.y != bank_tag[acc_ptr].y);
        drn_tag    = bank_tag[drn_ptr];
        row_end    = col == last_idx(drn_tag.size_type);
        last_elem  = row_end && (row == last_idx(drn_tag.size_type));
        wr_hs      = mem.mem_wr_en_o && mem.mem_wr_ready_i;
    end

    // Address/data are forced to zero while idle so the port reads 0 out of reset.
    assign mem.mem_wr_en_o   = d_state == D_WRITE;
    assign mem.mem_wr_od_o   = mem.mem_wr_en_o ? drn_tag.od : '0;
    assign mem.mem_wr_x_o    = mem.mem_wr_en_o ? drn_tag.x + 9'(row) : '0;
    assign mem.mem_wr_y_o    = mem.mem_wr_en_o ? drn_tag.y + 9'(col) : '0;
    assign mem.mem_wr_data_o = mem.mem_wr_en_o ? rd_data[drn_ptr] : '0;
    assign mem.group_done_o  = wr_hs && last_elem;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        wino_acc_bank #(.RES_W(RES_W), .ACC_W(ACC_W)) u_bank (
            .clk     (clk),
            .load    (accept && first_tile && (acc_ptr == 1'(b))),
            .add     (accept && !first_tile && (acc_ptr == 1'(b))),
            .tile_in (res.result_tile_i),
            .rd_row  (row),
            .rd_col  (col),
            .rd_data (rd_data[b])
        );
    end

    // Accept and drain never touch the same bank in one cycle: they act on disjoint states.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_state <= '{EMPTY, EMPTY};
            bank_tag   <= '{default: '0};
            acc_ptr    <= 1'b0;
            drn_ptr    <= 1'b0;
            tile_cnt   <= '0;
            id_target  <= '0;
            d_state    <= D_IDLE;
            row        <= '0;
            col        <= '0;
            overflow_o <= 1'b0;
            mismatch_o <= 1'b0;
        end else begin
            if (res.result_valid_i && !res.ready_o) overflow_o <= 1'b1;

            if (accept) begin
                if (first_tile)    bank_tag[acc_ptr] <= in_tag;
                else if (tag_diff) mismatch_o <= 1'b1;
                id_target <= tgt_next;
                if (tile_done) begin
                    bank_state[acc_ptr] <= FULL;
                    acc_ptr             <= ~acc_ptr;
                    tile_cnt            <= '0;
                end else begin
                    bank_state[acc_ptr] <= ACCUM;
                    tile_cnt            <= cnt_next;
                end
            end

            if (d_state == D_IDLE) begin
                if (bank_state[drn_ptr] == FULL) begin
                    bank_state[drn_ptr] <= DRAIN;
                    d_state             <= D_WRITE;
                    row                 <= '0;
                    col                 <= '0;
                end
            end else if (wr_hs) begin
                if (last_elem) begin
                    bank_state[drn_ptr] <= EMPTY;
                    drn_ptr             <= ~drn_ptr;
                    d_state             <= D_IDLE;
                    row                 <= '0;
                    col                 <= '0;
                end else if (row_end) begin
                    row <= row + 3'd1;
                    col <= '0;
                end else begin
                    col <= col + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wino_result_collector.sv
// Directed bench for wino_result_collector: table of tile groups plus hand-written
// overflow, mismatch, reset-mid-drain and 12-bit saturation sequences.
module tb_wino_result_collector;
    import winocnn_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wino_pe_result_if #(.RES_W(12)) res16 ();
    wino_mem_wr_if    #(.ACC_W(16)) mem16 ();
    wino_pe_result_if #(.RES_W(12)) res12 ();
    wino_mem_wr_if    #(.ACC_W(12)) mem12 ();
    logic ovf16, mis16, ovf12, mis12;

    wino_result_collector #(.RES_W(12), .ACC_W(16)) dut (
        .clk(clk), .reset(reset), .res(res16), .mem(mem16),
        .overflow_o(ovf16), .mismatch_o(mis16)
    );
    wino_result_collector #(.RES_W(12), .ACC_W(12)) dut12 (
        .clk(clk), .reset(reset), .res(res12), .mem(mem12),
        .overflow_o(ovf12), .mismatch_o(mis12)
    );

    typedef struct packed {
        int od; int x; int y; int data; int cyc; bit done;
    } wr_t;

    typedef struct packed {
        int n_tiles; int id_count; bit size; int od; int x; int y; int base;
        int sp0; int sp1; int sp2; int sp3; bit stall;
        int exp_other; int exp_sp; int exp_writes;
    } vec_t;

    int  checks = 0;
    int  failures = 0;
    wr_t wq[$];
    int  q12[$];
    int  done_cnt = 0;
    bit  stall_mode = 0;
    int  last_acc_cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory model for the 16-bit instance: optional stalls before handshakes 5..9.
    initial begin
        wr_t cur, snap;
        bit  held = 0, stalled = 0;
        mem16.mem_wr_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            cur = '{od: int'(mem16.mem_wr_od_o), x: int'(mem16.mem_wr_x_o),
                    y: int'(mem16.mem_wr_y_o), data: int'(mem16.mem_wr_data_o),
                    cyc: cyc, done: 1'b0};
            if (held)
                check("stall_hold", longint'(mem16.mem_wr_en_o && cur.od == snap.od && cur.x == snap.x
                      && cur.y == snap.y && cur.data == snap.data), 1);
            held = 0;
            if (stall_mode && wq.size() >= 4 && wq.size() <= 8 && !stalled) begin
                mem16.mem_wr_ready_i = 1'b0;
                stalled = 1;
            end else begin
                mem16.mem_wr_ready_i = 1'b1;
                stalled = 0;
            end
            #1;
            cur.done = mem16.group_done_o;
            if (mem16.group_done_o) done_cnt++;
            if (mem16.mem_wr_en_o && mem16.mem_wr_ready_i) wq.push_back(cur);
            else if (mem16.mem_wr_en_o) begin
                held = 1;
                snap = cur;
            end
        end
    end

    initial begin
        mem12.mem_wr_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            if (mem12.mem_wr_en_o) q12.push_back(int'(mem12.mem_wr_data_o));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
    task automatic send_tile(input int od, input int x, input int y, input bit size,
                             input int idc, input int base, input int sp, input bit honour);
        int k = 0;
        for (int r = 0; r < TILE_N; r++)
            for (int c = 0; c < TILE_N; c++)
                res16.result_tile_i[r][c] = 12'(base);
        res16.result_tile_i[2][3] = 12'(sp);
        res16.result_od_i    = 8'(od);
        res16.result_x_i     = 9'(x);
        res16.result_y_i     = 9'(y);
        res16.size_type_i    = size;
        res16.id_count_i     = 5'(idc);
        res16.result_valid_i = 1'b1;
        if (honour) begin
            while (!res16.ready_o && k < 500) begin
                @(negedge clk);
                k++;
            end
            if (k >= 500) check("send_ready_timeout", 0, 1);
        end
        @(negedge clk);
        last_acc_cyc = cyc;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic count_data(input int lo, input int hi, input int exp, output int errs);
        errs = 0;
        for (int i = lo; i < hi; i++)
            if (i >= wq.size() || wq[i].data != exp) errs++;
    endtask

    vec_t vecs[6];

    initial begin
        int errs, addr_err, data_err, done_err, idx, last, ed, sp, first_lat, span;

        reset = 1'b1;
        for (int r = 0; r < TILE_N; r++)
            for (int c = 0; c < TILE_N; c++) begin
                res16.result_tile_i[r][c] = '0;
                res12.result_tile_i[r][c] = '0;
            end
        res16.result_valid_i = 0; res16.result_od_i = 0; res16.result_x_i = 0;
        res16.result_y_i = 0; res16.size_type_i = 0; res16.id_count_i = 0;
        res12.result_valid_i = 0; res12.result_od_i = 0; res12.result_x_i = 0;
        res12.result_y_i = 0; res12.size_type_i = 0; res12.id_count_i = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_ready", res16.ready_o, 1);
        check("rst_wr_en", mem16.mem_wr_en_o, 0);
        check("rst_done", mem16.group_done_o, 0);
        check("rst_overflow", ovf16, 0);
        check("rst_mismatch", mis16, 0);
        check("rst_wr_od", mem16.mem_wr_od_o, 0);
        check("rst_wr_data", mem16.mem_wr_data_o, 0);

        // 12-bit accumulator instance: two groups of two tiles, saturating both ways.
        res12.id_count_i = 5'd2;
        res12.result_valid_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < TILE_N; r++)
                for (int c = 0; c < TILE_N; c++)
                    res12.result_tile_i[r][c] = (t < 2) ? 12'sd2047 : -12'sd2048;
            res12.result_od_i = 8'(t / 2);
            @(negedge clk);
        end
        res12.result_valid_i = 1'b0;

        vecs[0] = '{n_tiles: 1, id_count: 1, size: 0, od: 3, x: 8, y: 16, base: 5,
                    sp0: 5, sp1: 5, sp2: 5, sp3: 5, stall: 0,
                    exp_other: 5, exp_sp: 5, exp_writes: 36};
        vecs[1] = '{n_tiles: 4, id_count: 4, size: 0, od: 1, x: 40, y: 50, base: 1,
                    sp0: 10, sp1: 20, sp2: -5, sp3: 100, stall: 0,
                    exp_other: 4, exp_sp: 125, exp_writes: 36};
        vecs[2] = '{n_tiles: 1, id_count: 0, size: 0, od: 255, x: 500, y: 300, base: -7,
                    sp0: -7, sp1: -7, sp2: -7, sp3: -7, stall: 0,
                    exp_other: -7, exp_sp: -7, exp_writes: 36};
        vecs[3] = '{n_tiles: 2, id_count: 2, size: 1, od: 9, x: 100, y: 200, base: 3,
                    sp0: 50, sp1: -60, sp2: 0, sp3: 0, stall: 0,
                    exp_other: 6, exp_sp: -10, exp_writes: 16};
        vecs[4] = '{n_tiles: 16, id_count: 16, size: 0, od: 128, x: 0, y: 0, base: 2047,
                    sp0: -2048, sp1: -2048, sp2: -2048, sp3: -2048, stall: 0,
                    exp_other: 32752, exp_sp: -32768, exp_writes: 36};
        vecs[5] = '{n_tiles: 1, id_count: 1, size: 0, od: 7, x: 64, y: 32, base: -100,
                    sp0: 1234, sp1: 1234, sp2: 1234, sp3: 1234, stall: 1,
                    exp_other: -100, exp_sp: 1234, exp_writes: 36};

        for (int v = 0; v < 6; v++) begin
            wq.delete();
            done_cnt = 0;
            stall_mode = vecs[v].stall;
            for (int t = 0; t < vecs[v].n_tiles; t++) begin
                sp = (t == 0) ? vecs[v].sp0 : (t == 1) ? vecs[v].sp1
                   : (t == 2) ? vecs[v].sp2 : vecs[v].sp3;
                send_tile(vecs[v].od, vecs[v].x, vecs[v].y, vecs[v].size,
                          vecs[v].id_count, vecs[v].base, sp, 1'b1);
            end
            res16.result_valid_i = 1'b0;
            wait_writes(vecs[v].exp_writes, 400);
            repeat (4) @(negedge clk);

            last = vecs[v].size ? 3 : 5;
            idx = 0; addr_err = 0; data_err = 0; done_err = 0;
            for (int r = 0; r <= last; r++) begin
                for (int c = 0; c <= last; c++) begin
                    if (idx < wq.size()) begin
                        if (wq[idx].od != vecs[v].od || wq[idx].x != vecs[v].x + r
                            || wq[idx].y != vecs[v].y + c) addr_err++;
                        ed = (r == 2 && c == 3) ? vecs[v].exp_sp : vecs[v].exp_other;
                        if (wq[idx].data != ed) data_err++;
                        if (wq[idx].done != (idx == vecs[v].exp_writes - 1)) done_err++;
                    end
                    idx++;
                end
            end
            first_lat = (wq.size() > 0) ? wq[0].cyc - last_acc_cyc : -1;
            span      = (wq.size() > 0) ? wq[wq.size()-1].cyc - last_acc_cyc : -1;

            check($sformatf("v%0d_write_count", v), wq.size(), vecs[v].exp_writes);
            check($sformatf("v%0d_addr_errors", v), addr_err, 0);
            check($sformatf("v%0d_data_errors", v), data_err, 0);
            check($sformatf("v%0d_done_position_errors", v), done_err, 0);
            check($sformatf("v%0d_done_pulses", v), done_cnt, 1);
            check($sformatf("v%0d_first_write_latency", v), first_lat, 1);
            check($sformatf("v%0d_last_write_cycle", v), span,
                  vecs[v].exp_writes + (vecs[v].stall ? 5 : 0));
            check($sformatf("v%0d_overflow", v), ovf16, 0);
            check($sformatf("v%0d_mismatch", v), mis16, 0);
        end
        stall_mode = 0;

        // Three back-to-back tiles ignoring ready: third is dropped.
        wq.delete();
        done_cnt = 0;
        check("bb_ready_before", res16.ready_o, 1);
        send_tile(2, 10, 20, 0, 1, 11, 11, 1'b0);
        send_tile(2, 30, 40, 0, 1, 22, 22, 1'b0);
        check("bb_ready_cycle3", res16.ready_o, 0);
        send_tile(2, 50, 60, 0, 1, 33, 33, 1'b0);
        res16.result_valid_i = 1'b0;
        check("bb_overflow", ovf16, 1);
        wait_writes(72, 400);
        repeat (4) @(negedge clk);
        check("bb_write_count", wq.size(), 72);
        count_data(0, 36, 11, errs);
        check("bb_tile1_data_errors", errs, 0);
        count_data(36, 72, 22, errs);
        check("bb_tile2_data_errors", errs, 0);
        check("bb_tile2_base_x", (wq.size() > 36) ? wq[36].x : -1, 30);
        check("bb_done_pulses", done_cnt, 2);

        // Second tile of a group carries a different y tag.
        wq.delete();
        send_tile(5, 10, 16, 0, 2, 2, 2, 1'b1);
        send_tile(5, 10, 17, 0, 2, 3, 3, 1'b1);
        res16.result_valid_i = 1'b0;
        check("mm_mismatch", mis16, 1);
        wait_writes(36, 400);
        repeat (4) @(negedge clk);
        check("mm_write_count", wq.size(), 36);
        count_data(0, 36, 5, errs);
        check("mm_data_errors", errs, 0);
        check("mm_first_y", (wq.size() > 0) ? wq[0].y : -1, 16);

        // 4x4 drain interrupted by reset while write 7 is on the port.
        wq.delete();
        send_tile(6, 20, 30, 1, 1, 9, 9, 1'b1);
        res16.result_valid_i = 1'b0;
        wait_writes(6, 200);
        check("rd_write4_x", (wq.size() > 4) ? wq[4].x : -1, 21);
        check("rd_write4_y", (wq.size() > 4) ? wq[4].y : -1, 30);
        check("rd_write3_y", (wq.size() > 3) ? wq[3].y : -1, 33);
        reset = 1'b1;
        @(negedge clk);
        check("rd_wr_en_after_reset", mem16.mem_wr_en_o, 0);
        check("rd_ready_after_reset", res16.ready_o, 1);
        check("rd_overflow_cleared", ovf16, 0);
        check("rd_mismatch_cleared", mis16, 0);
        check("rd_done_after_reset", mem16.group_done_o, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rd_no_further_writes", wq.size(), 7);

        wq.delete();
        done_cnt = 0;
        send_tile(2, 1, 2, 1, 1, -3, -3, 1'b1);
        res16.result_valid_i = 1'b0;
        wait_writes(16, 200);
        repeat (4) @(negedge clk);
        check("post_reset_write_count", wq.size(), 16);
        count_data(0, 16, -3, errs);
        check("post_reset_data_errors", errs, 0);
        check("post_reset_last_x", (wq.size() > 15) ? wq[15].x : -1, 4);
        check("post_reset_last_y", (wq.size() > 15) ? wq[15].y : -1, 5);
        check("post_reset_done_pulses", done_cnt, 1);

        // Saturation results from the 12-bit instance (long since drained).
        check("sat_write_count", q12.size(), 72);
        errs = 0;
        for (int i = 0; i < 72; i++)
            if (i >= q12.size() || q12[i] != ((i < 36) ? 2047 : -2048)) errs++;
        check("sat_data_errors", errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
